i2s_mic_receiver: RTL



---
 rtl/i2s_mic_receiver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_mic_receiver.sv
// -----------------------------------------------------------------------------
// i2s_mic_receiver
//
// I2S bus master and receiver for one stereo pair of MEMS microphones. The
// block generates SCK and WS from the system clock and deserialises one
// MSB-first sample per slot from the shared SD line. Each completed
// left/right pair is presented with a one-clk valid strobe.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       run request (level); sampled for stop only at a frame wrap
//   sd           serial data from the microphones
//   sck          generated serial clock, 50% duty, period 2*SCK_DIV clk
//   ws           word select, 0 = left slot, 1 = right slot
//   left_sample  last complete left sample (two's complement)
//   right_sample last complete right sample (two's complement)
//   sample_valid one-clk pulse when left_sample/right_sample update
//   busy         high while the bus is running
// -----------------------------------------------------------------------------
module i2s_mic_receiver #(
  parameter int unsigned SCK_DIV    = 16,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sd,
  output logic                  sck,
  output logic                  ws,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  output logic                  busy
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = $clog2(SCK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_K   = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] DATA_K   = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] COMMIT_K = CNT_W'(SLOT_WIDTH + DATA_WIDTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  ws_q, ws_d;
  logic                  sd_q;
  logic                  first_frame_q, first_frame_d;
  logic                  commit_q, commit_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] left_sr_q, left_sr_d;
  logic [DATA_WIDTH-1:0] right_sr_q, right_sr_d;
  logic [DATA_WIDTH-1:0] left_sample_q, left_sample_d;
  logic [DATA_WIDTH-1:0] right_sample_q, right_sample_d;

  // SCK edge events, decoded one clk ahead from the divider.
  logic             tick, rise_evt, fall_evt, frame_wrap;
  logic [CNT_W-1:0] slot_pos, slot_bit, bit_cnt_inc;
  logic             in_right, capture;

  assign tick       = (state_q == ST_RUN) && (div_cnt_q == DIV_LAST);
  assign rise_evt   = tick && !sck_q;
  assign fall_evt   = tick && sck_q;
  assign frame_wrap = fall_evt && (bit_cnt_q == BIT_LAST);
  assign bit_cnt_inc = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;

  // One-bit I2S delay: the rising edge at bit_cnt=k carries frame bit k-1.
  assign slot_pos = (bit_cnt_q == '0) ? BIT_LAST : bit_cnt_q - 1'b1;
  assign in_right = (slot_pos >= SLOT_K);
  assign slot_bit = in_right ? slot_pos - SLOT_K : slot_pos;
  assign capture  = (slot_bit < DATA_K);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  // NOTE: the shift registers are ordinary flops and are reset with the rest,
  // so a partial frame never leaks into a later commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      sck_q          <= 1'b0;
      ws_q           <= 1'b0;
      sd_q           <= 1'b0;
      first_frame_q  <= 1'b1;
      commit_q       <= 1'b0;
      valid_q        <= 1'b0;
      left_sr_q      <= '0;
      right_sr_q     <= '0;
      left_sample_q  <= '0;
      right_sample_q <= '0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      sck_q          <= sck_d;
      ws_q           <= ws_d;
      sd_q           <= sd;
      first_frame_q  <= first_frame_d;
      commit_q       <= commit_d;
      valid_q        <= valid_d;
      left_sr_q      <= left_sr_d;
      right_sr_q     <= right_sr_d;
      left_sample_q  <= left_sample_d;
      right_sample_q <= right_sample_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    sck_d          = sck_q;
    ws_d           = ws_q;
    first_frame_d  = first_frame_q;
    commit_d       = 1'b0;
    valid_d        = 1'b0;
    left_sr_d      = left_sr_q;
    right_sr_d     = right_sr_q;
    left_sample_d  = left_sample_q;
    right_sample_d = right_sample_q;

    // The right slot finished on the previous clk; publish the pair.
    if (commit_q) begin
      left_sample_d  = left_sr_q;
      right_sample_d = right_sr_q;
      valid_d        = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        sck_d     = 1'b0;
        ws_d      = 1'b0;
        div_cnt_d = '0;
        if (enable) begin
          state_d       = ST_RUN;
          bit_cnt_d     = '0;
          first_frame_d = 1'b1;
        end
      end
      ST_RUN: begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        if (rise_evt) begin
          sck_d = 1'b1;
          if (capture) begin
            if (in_right) right_sr_d = (right_sr_q << 1) | DATA_WIDTH'(sd_q);
            else          left_sr_d  = (left_sr_q << 1) | DATA_WIDTH'(sd_q);
          end
          // Mics need a full WS cycle to lock, so the first frame is dropped.
          if ((bit_cnt_q == COMMIT_K) && !first_frame_q) commit_d = 1'b1;
        end
        if (fall_evt) begin
          sck_d     = 1'b0;
          bit_cnt_d = bit_cnt_inc;
          ws_d      = (bit_cnt_inc >= SLOT_K);
          if (frame_wrap) begin
            first_frame_d = 1'b0;
            // Stop only at a frame boundary so the current pair completes.
            if (!enable) state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Output logic.
  always_comb begin
    sck          = sck_q;
    ws           = ws_q;
    left_sample  = left_sample_q;
    right_sample = right_sample_q;
    sample_valid = valid_q;
    busy         = (state_q == ST_RUN);
  end

endmodule
